// File: rtl/demux_deserializer_pkg.sv
// rtl/demux_deserializer_pkg.sv - shared state encoding and default width for the serial demux receiver
package demux_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PARITY  = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/demux_slot_decoder.sv
// rtl/demux_slot_decoder.sv - one-hot slot write-enable decoder, inverse of the mux select decode
module demux_slot_decoder #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] we
);

    always_comb begin
        we = '0;
        for (int i = 0; i < WIDTH; i++) begin
            we[i] = en && (idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux_deserializer.sv
// rtl/demux_deserializer.sv - 1:WIDTH serial demux with valid/ready word output; DEMUX_PARITY_EN adds a trailing even-parity bit
module demux_deserializer
    import demux_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             valid_d;
    logic             accept;
    logic             data_acc;
    logic             parity_acc;
    logic [WIDTH-1:0] we;

    assign din_ready = !out_valid || out_ready;
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = out_valid;
        data_acc   = 1'b0;
        parity_acc = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    data_acc = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef DEMUX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_FULL;
                        valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                end
            end
`ifdef DEMUX_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    parity_acc = 1'b1;
                    state_d    = ST_FULL;
                    valid_d    = 1'b1;
                end
            end
`endif
            ST_FULL: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_COLLECT;
                    // a bit arriving with the consume is bit 0 of the next word (cnt_q is already 0)
                    if (din_valid) begin
                        data_acc = 1'b1;
                        cnt_d    = SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    demux_slot_decoder #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_decoder (
        .idx (cnt_q),
        .en  (data_acc),
        .we  (we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= valid_d;
            out_data  <= (out_data & ~we) | (we & {WIDTH{din}});
            if (data_acc) begin
                sel <= cnt_q;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (parity_acc) begin
            err_q <= (^out_data) ^ din;
        end
    end

    assign out_err = err_q;
`else
    logic unused_parity;

    assign unused_parity = parity_acc;
    assign out_err       = 1'b0;
`endif

endmodule

// File: tb/tb_demux_deserializer.sv
// tb/tb_demux_deserializer.sv - scoreboard bench for demux_deserializer (default and DEMUX_PARITY_EN builds)
module tb_demux_deserializer;

`ifdef DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [2:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic [2:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   checked = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    demux_deserializer #(.WIDTH(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each presented word once, then verify it is held until consumed.
    always @(negedge clk) begin
        if (rst) begin
            checked = 1'b0;
        end else if (out_valid) begin
            if (!checked) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                    cur = '{data: out_data, err: out_err, sel: sel};
                end else begin
                    cur = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(cur.data));
                    chk("word_err",  32'(out_err),  32'(cur.err));
                    chk("word_sel",  32'(sel),      32'(cur.sel));
                end
                checked = 1'b1;
            end else begin
                chk("hold_data", 32'(out_data), 32'(cur.data));
                chk("hold_err",  32'(out_err),  32'(cur.err));
                chk("hold_sel",  32'(sel),      32'(cur.sel));
            end
            if (out_ready) checked = 1'b0;
        end
    end

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Sends bits start..7 of d, then the parity bit in the parity build; out_ready must be 0.
    task automatic send_from(input logic [7:0] d, input int start, input logic flip);
        exp_q.push_back('{data: d, err: PAR ? flip : 1'b0, sel: 3'd7});
        for (int i = start; i < 8; i++) begin
            send_bit(d[i]);
            chk("valid_during_frame", 32'(out_valid), 32'((i == 7) && !PAR));
        end
        if (PAR) begin
            send_bit((^d) ^ flip);
            chk("valid_after_parity", 32'(out_valid), 32'd1);
        end
        chk("full_sel", 32'(sel), 32'd7);
        chk("full_din_ready", 32'(din_ready), 32'd0);
    endtask

    task automatic consume();
        din_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("consumed_din_ready", 32'(din_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'h00);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_din_ready", 32'(din_ready), 32'd1);
        chk("reset_err", 32'(out_err), 32'd0);
        rst       = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;

        // Basic word 1,0,0,1,0,0,1,1 -> 8'hC9
        send_from(8'hC9, 0, 1'b0);

        // Backpressure: source offers bits while the word is held
        din       = 1'b0;
        din_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_data", 32'(out_data), 32'hC9);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sel", 32'(sel), 32'd7);
        consume();

        // Simultaneous consume and accept of bit 0 of the next word
        send_from(8'hA5, 0, 1'b0);
        out_ready = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        din_valid = 1'b0;
        chk("simul_valid", 32'(out_valid), 32'd0);
        chk("simul_sel", 32'(sel), 32'd0);
        chk("simul_din_ready", 32'(din_ready), 32'd1);
        send_from(8'h01, 1, 1'b0);
        consume();

        // Reset mid-word discards the partial word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_data", 32'(out_data), 32'h00);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        send_from(8'hFF, 0, 1'b0);
        consume();

`ifdef DEMUX_PARITY_EN
        send_from(8'hC9, 0, 1'b0);
        consume();
        send_from(8'hC9, 0, 1'b1);
        consume();
`else
        // Ninth bit opens a new word
        send_from(8'hC9, 0, 1'b0);
        consume();
        send_bit(1'b1);
        chk("ninth_sel", 32'(sel), 32'd0);
        chk("ninth_valid", 32'(out_valid), 32'd0);
        send_from(8'h01, 1, 1'b0);
        consume();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
